// File: rtl/vend_pkg.sv
// Shared types and constants for the coin-credit vending controller.
package vend_pkg;

  localparam int MONEY_W = 8;

  localparam logic [MONEY_W-1:0] DEFAULT_PRICE      = 8'd125;
  localparam logic [MONEY_W-1:0] DEFAULT_MAX_CREDIT = 8'd255;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_DISPENSE,
    S_REFUND
  } state_t;

  // The sum is one bit wider than the credit register, so a carry out always counts as overflow.
  function automatic logic coin_fits(input logic [MONEY_W:0]   sum,
                                     input logic [MONEY_W-1:0] ceiling);
    return sum <= {1'b0, ceiling};
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector: one event per low-to-high transition of a level.
module edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic rise
);

  logic level_q;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  // Clearing level_q in reset makes a level already high at release count as an event.
  assign rise = level & ~level_q;

endmodule

// File: rtl/vend_credit.sv
// Vending credit controller: accumulates coins, dispenses against PRICE, refunds on cancel.
module vend_credit
  import vend_pkg::*;
#(
  parameter logic [MONEY_W-1:0] PRICE      = DEFAULT_PRICE,
  parameter logic [MONEY_W-1:0] MAX_CREDIT = DEFAULT_MAX_CREDIT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               coin,
  input  logic [MONEY_W-1:0] money,
  input  logic               buy,
  input  logic               cancel,
  output logic [MONEY_W-1:0] credit,
  output logic               vend,
  output logic [MONEY_W-1:0] change,
  output logic               change_valid,
  output logic               reject,
  output logic               busy
);

  state_t             state;
  logic               coin_ev;
  logic               buy_ev;
  logic               cancel_ev;
  logic [MONEY_W:0]   sum;
  logic               fits;
  logic               in_hold;
  logic               buy_ok;
  logic               cancel_ok;

  edge_detect u_coin_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (coin),
    .rise    (coin_ev)
  );

  edge_detect u_buy_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (buy),
    .rise    (buy_ev)
  );

  edge_detect u_cancel_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (cancel),
    .rise    (cancel_ev)
  );

  assign sum       = {1'b0, credit} + {1'b0, money};
  assign fits      = coin_fits(sum, MAX_CREDIT);
  assign in_hold   = (state == S_HOLD);
  assign cancel_ok = cancel_ev & in_hold;
  assign buy_ok    = buy_ev & in_hold & (credit >= PRICE);

  // Priority: accepted cancel, then accepted buy, then coin; a displaced coin is returned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      credit       <= '0;
      change       <= '0;
      vend         <= 1'b0;
      change_valid <= 1'b0;
      reject       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle so each branch only states when they fire.
      vend         <= 1'b0;
      change_valid <= 1'b0;
      reject       <= 1'b0;

      unique case (state)
        S_IDLE, S_HOLD: begin
          if (cancel_ok) begin
            state  <= S_REFUND;
            busy   <= 1'b1;
            reject <= coin_ev;
          end else if (buy_ok) begin
            state  <= S_DISPENSE;
            vend   <= 1'b1;
            busy   <= 1'b1;
            reject <= coin_ev;
          end else if (coin_ev) begin
            if (fits) begin
              credit <= sum[MONEY_W-1:0];
              state  <= S_HOLD;
            end else begin
              reject <= 1'b1;
            end
          end
        end

        S_DISPENSE: begin
          change       <= credit - PRICE;
          change_valid <= 1'b1;
          credit       <= '0;
          busy         <= 1'b0;
          reject       <= coin_ev;
          state        <= S_IDLE;
        end

        // Credit is only released on leaving REFUND, so a reset here forfeits it silently.
        S_REFUND: begin
          change       <= credit;
          change_valid <= 1'b1;
          credit       <= '0;
          busy         <= 1'b0;
          reject       <= coin_ev;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/vend_credit.md
VEND_CREDIT -- requirements
Module: vend_credit

Interface
REQ-001 Parameter PRICE, default 8'd125, item price in cents.
REQ-002 Parameter MAX_CREDIT, default 8'd255, credit ceiling in cents.
REQ-003 CLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 COIN  input  1  coin-insert level from front panel, synchronous to CLK; a rising edge means one coin.
REQ-006 MONEY  input  8  coin value in cents from the coin-value selector (5/10/25/100).
REQ-007 BUY  input  1  purchase request level; a rising edge means one request.
REQ-008 CANCEL  input  1  refund request level; a rising edge means one request.
REQ-009 CREDIT  output  8  accumulated credit in cents.
REQ-010 VEND  output  1  one-cycle pulse: dispense one item.
REQ-011 CHANGE  output  8  change/refund amount, held until the next CHANGE_VALID.
REQ-012 CHANGE_VALID  output  1  one-cycle pulse: CHANGE has been updated.
REQ-013 REJECT  output  1  one-cycle pulse: coin returned, not credited.
REQ-014 BUSY  output  1  high in DISPENSE and REFUND states.

Function
REQ-015 Event detection SHALL be registered: edge = input & ~input_q, evaluated at each CLK rising edge; holding a level high SHALL yield exactly one event.
REQ-016 FSM states SHALL be IDLE (credit 0), HOLD (credit > 0), DISPENSE, REFUND.
REQ-017 A coin event in IDLE/HOLD SHALL form a 9-bit sum CREDIT+MONEY; if sum <= MAX_CREDIT, CREDIT takes the sum at that same edge and the state becomes HOLD; otherwise CREDIT is unchanged and REJECT pulses.
REQ-018 MONEY SHALL be sampled only at the edge on which the coin event is detected.
REQ-019 A BUY event in HOLD with CREDIT >= PRICE SHALL go to DISPENSE; in DISPENSE VEND is high for exactly one cycle.
REQ-020 The cycle after DISPENSE, CHANGE SHALL equal CREDIT-PRICE (8-bit, never negative), CHANGE_VALID SHALL pulse, CREDIT SHALL become 0, and the state SHALL become IDLE.
REQ-021 A BUY event with CREDIT < PRICE, or any BUY in IDLE, SHALL be ignored, with no output change.
REQ-022 A CANCEL event in HOLD SHALL go to REFUND; in REFUND CHANGE SHALL equal CREDIT, CHANGE_VALID SHALL pulse, CREDIT SHALL become 0, and the next state SHALL be IDLE; CANCEL in IDLE SHALL be ignored.
REQ-023 Simultaneous events SHALL be prioritised CANCEL > BUY(accepted) > coin; a coin event that coincides with an accepted CANCEL/BUY, or that arrives in DISPENSE/REFUND, SHALL pulse REJECT and not be credited.
REQ-024 BUY/CANCEL events arriving in DISPENSE/REFUND SHALL be discarded.
REQ-025 Latency: a coin edge is reflected on CREDIT 1 cycle after detection; a BUY produces VEND 1 cycle after detection and CHANGE_VALID 2 cycles after detection.
REQ-026 PRICE SHALL satisfy 0 < PRICE <= MAX_CREDIT; PRICE = MAX_CREDIT exactly SHALL remain purchasable.

Reset
REQ-027 While RESET_N is low: state IDLE; CREDIT, CHANGE = 0; VEND, CHANGE_VALID, REJECT, BUSY = 0; edge registers = 0.
REQ-028 Reset asserted mid-DISPENSE/REFUND SHALL abort the operation with no VEND/CHANGE_VALID pulse, and credit is lost.
REQ-029 A level already high when RESET_N releases SHALL count as an event on the first clock edge.

Structure
REQ-030 Package vend_pkg SHALL hold the state enumeration, default PRICE and MAX_CREDIT, and the money width (8).
REQ-031 Sub-module edge_detect (1-bit rising-edge, async active-low reset) SHALL be instantiated once each for COIN, BUY and CANCEL.
REQ-032 The datapath (9-bit add, compare, subtract) and the FSM SHALL reside in vend_credit.

Verification
REQ-033 Coins 100,25 -> CREDIT 100 then 125; BUY -> VEND 1 cycle, then CHANGE=0 with CHANGE_VALID, CREDIT=0.
REQ-034 Coins 100,100 then BUY -> VEND; CHANGE=75, CHANGE_VALID pulses once.
REQ-035 Coins 25,10 then BUY -> no VEND; CANCEL -> CHANGE=35, CHANGE_VALID, CREDIT=0, state IDLE.
REQ-036 Credit 250, coin 10 -> REJECT pulse, CREDIT stays 250; coin 5 -> CREDIT 255.
REQ-037 Credit 125, BUY and coin 25 edges in the same cycle -> VEND, REJECT, CHANGE=0; COIN held high 20 cycles -> one credit only.
REQ-038 RESET_N low during DISPENSE -> VEND not asserted afterward, CREDIT=0, CHANGE=0.
